// File: rtl/tia_phase_counter.sv
// Two-phase (s1/s2) clock generator driving a 6-bit XNOR polynomial counter.
// The counter advances on the falling edge of s1, matching the D1 latch timing.
module tia_phase_counter #(
  parameter logic [5:0] END_VALUE      = 6'b010100,
  parameter bit         PHASE_EN_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       res_req,
  output logic       s1,
  output logic       s2,
  output logic [5:0] count,
  output logic       at_end,
  output logic       wrap
);

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_S1   = 2'b01,
    PH_MID  = 2'b11,
    PH_S2   = 2'b10
  } phase_e;

  phase_e     ph_q, ph_d;
  logic [5:0] count_q, count_d;
  logic       pend_q, pend_d;
  logic       wrap_q, wrap_d;
  logic       run_q, run_d;
  logic       tick;

  assign tick = en && run_q && (ph_q == PH_S1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q    <= PH_IDLE;
      count_q <= 6'b000000;
      pend_q  <= 1'b0;
      wrap_q  <= 1'b0;
      run_q   <= PHASE_EN_RESET;
    end else begin
      ph_q    <= ph_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      wrap_q  <= wrap_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    ph_d    = ph_q;
    count_d = count_q;
    pend_d  = pend_q;
    wrap_d  = 1'b0;
    run_d   = run_q;

    if (en) begin
      // A count-reset request also releases a sequencer held since reset.
      if (res_req) run_d = 1'b1;

      if (run_q) begin
        unique case (ph_q)
          PH_IDLE: ph_d = PH_S1;
          PH_S1:   ph_d = PH_MID;
          PH_MID:  ph_d = PH_S2;
          PH_S2:   ph_d = PH_IDLE;
          default: ph_d = PH_IDLE;
        endcase
      end

      if (tick) begin
        if (pend_q || res_req) begin
          count_d = 6'b000000;
          pend_d  = 1'b0;
        end else if (count_q == END_VALUE) begin
          count_d = 6'b000000;
          wrap_d  = 1'b1;
        end else begin
          count_d = {count_q[4:0], ~(count_q[5] ^ count_q[4])};
        end
      end else if (res_req) begin
        pend_d = 1'b1;
      end
    end
  end

  assign s1     = (ph_q == PH_S1);
  assign s2     = (ph_q == PH_S2);
  assign count  = count_q;
  assign at_end = (count_q == END_VALUE);
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_tia_phase_counter.sv
// Scoreboard bench for tia_phase_counter: one instance free-running after reset,
// one held until the first res_req, both compared against a cycle-position model.
module tb_tia_phase_counter;

  localparam logic [5:0] END_VALUE = 6'b010100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b0;
  logic       res_req = 1'b0;
  logic       s1_a, s2_a, at_end_a, wrap_a;
  logic [5:0] count_a;
  logic       s1_b, s2_b, at_end_b, wrap_b;
  logic [5:0] count_b;

  int checks = 0;
  int passes = 0;

  // Model per instance: position within the 4-clk phase cycle, counter value, flags.
  int         m_pos [2];
  logic [5:0] m_cnt [2];
  bit         m_pend[2];
  bit         m_run [2];
  bit         m_wrap[2];

  logic [19:0] exp_q[$];

  tia_phase_counter #(.END_VALUE(END_VALUE), .PHASE_EN_RESET(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .res_req(res_req),
    .s1(s1_a), .s2(s2_a), .count(count_a), .at_end(at_end_a), .wrap(wrap_a)
  );

  tia_phase_counter #(.END_VALUE(END_VALUE), .PHASE_EN_RESET(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .res_req(res_req),
    .s1(s1_b), .s2(s2_b), .count(count_b), .at_end(at_end_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] poly_next(input logic [5:0] c);
    return {c[4:0], ~(c[5] ^ c[4])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i]  = 0;
      m_cnt[i]  = 6'b0;
      m_pend[i] = 1'b0;
      m_wrap[i] = 1'b0;
      m_run[i]  = (i == 0);
    end
  endtask

  task automatic model_step(input bit e, input bit r);
    for (int i = 0; i < 2; i++) begin
      bit nw = 1'b0;
      if (e) begin
        if (!m_run[i]) begin
          if (r) begin
            m_run[i]  = 1'b1;
            m_pend[i] = 1'b1;
          end
        end else begin
          if (m_pos[i] == 1) begin
            if (m_pend[i] || r) begin
              m_cnt[i]  = 6'b0;
              m_pend[i] = 1'b0;
            end else if (m_cnt[i] == END_VALUE) begin
              m_cnt[i] = 6'b0;
              nw = 1'b1;
            end else begin
              m_cnt[i] = poly_next(m_cnt[i]);
            end
          end else if (r) begin
            m_pend[i] = 1'b1;
          end
          m_pos[i] = (m_pos[i] + 1) % 4;
        end
      end
      m_wrap[i] = nw;
    end
  endtask

  function automatic logic [9:0] exp_word(input int i);
    return {m_pos[i] == 1, m_pos[i] == 3, m_cnt[i], m_cnt[i] == END_VALUE, m_wrap[i]};
  endfunction

  task automatic check_output(input string name, input logic [9:0] act, input logic [9:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("[TB] FAIL %s actual={s1,s2,count,at_end,wrap}=%b required=%b at %0t",
                  name, act, exp_v, $time);
  endtask

  task automatic apply_stimulus(input bit e, input bit r);
    @(negedge clk);
    en = e;
    res_req = r;
    if (reset_n) model_step(e, r);
    else model_reset();
    exp_q.push_back({exp_word(0), exp_word(1)});
  endtask

  task automatic run_n(input int n, input bit e, input bit r);
    for (int k = 0; k < n; k++) apply_stimulus(e, r);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    model_reset();
    reset_n = 1'b0;
    #1;
    check_output("async_reset_a", {s1_a, s2_a, count_a, at_end_a, wrap_a}, 10'b0);
    check_output("async_reset_b", {s1_b, s2_b, count_b, at_end_b, wrap_b}, 10'b0);
    run_n(2, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  // Monitor: every clk the DUTs present a fresh state; compare against the queue.
  initial begin
    logic [19:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("sb_a", {s1_a, s2_a, count_a, at_end_a, wrap_a}, e[19:10]);
        check_output("sb_b", {s1_b, s2_b, count_b, at_end_b, wrap_b}, e[9:0]);
      end
    end
  end

  initial begin
    bit found;
    #2;
    do_reset();

    // Free run through a full period from reset.
    run_n(234, 1'b1, 1'b0);
    settle();
    check_output("tick59_end", {s1_a, s2_a, count_a, at_end_a, wrap_a},
                 {1'b0, 1'b0, END_VALUE, 1'b1, 1'b0});
    check_output("held_b_idle", {s1_b, s2_b, count_b, at_end_b, wrap_b}, 10'b0);
    run_n(4, 1'b1, 1'b0);
    settle();
    check_output("tick60_wrap", {wrap_a, count_a}, {1'b1, 6'b000000});
    run_n(1, 1'b1, 1'b0);
    settle();
    check_output("wrap_one_clk", {wrap_a, count_a}, {1'b0, 6'b000000});
    run_n(3, 1'b1, 1'b0);
    settle();
    check_output("tick61_count", {wrap_a, count_a}, {1'b0, 6'b000001});

    // res_req on a non-tick clk while count = 011111.
    @(posedge clk);
    #3;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_cnt[0] == 6'b011111 && m_pos[0] == 2) found = 1'b1;
      else apply_stimulus(1'b1, 1'b0);
    end
    check_output("find_011111", {9'b0, found}, 10'd1);
    apply_stimulus(1'b1, 1'b1);
    settle();
    check_output("pend_hold", {wrap_a, count_a}, {1'b0, 6'b011111});
    run_n(6, 1'b1, 1'b0);

    // res_req on the very tick where count == END_VALUE.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_cnt[0] == END_VALUE && m_pos[0] == 1) found = 1'b1;
      else apply_stimulus(1'b1, 1'b0);
    end
    check_output("find_end_tick", {9'b0, found}, 10'd1);
    apply_stimulus(1'b1, 1'b1);
    settle();
    check_output("reset_beats_wrap", {wrap_a, count_a}, {1'b0, 6'b000000});

    // en low for 10 clks while s1 is high.
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (m_pos[0] == 1) found = 1'b1;
      else apply_stimulus(1'b1, 1'b0);
    end
    check_output("find_s1", {9'b0, found}, 10'd1);
    run_n(10, 1'b0, 1'b1);
    run_n(4, 1'b1, 1'b0);

    // Asynchronous reset mid-sequence at count = 110101, ph = 11.
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_cnt[0] == 6'b110101 && m_pos[0] == 2) found = 1'b1;
      else apply_stimulus(1'b1, 1'b0);
    end
    check_output("find_110101", {9'b0, found}, 10'd1);
    @(posedge clk);
    #3;
    do_reset();
    run_n(20, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    run_n(12, 1'b1, 1'b0);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++)
      apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);

    settle();
    settle();
    if (exp_q.size() != 0) check_output("queue_drained", 10'(exp_q.size()), 10'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tia_phase_counter.md
Name: tia_phase_counter

Overview:
- Two-phase clock generator plus 6-bit polynomial (LFSR) counter.
- Sits directly upstream of the tia_d1 shift stages: drives their s1/s2 phase inputs and supplies the counter state that D1 chains sample and decode.
- Models the TIA horizontal counter front end (master clock to phi1/phi2 to polynomial count) in a single synchronous domain.

Parameters:
- END_VALUE, 6'b010100, counter state that forces a wrap to 000000 on the next tick.
- PHASE_EN_RESET, 1'b1, phase sequencer runs after reset when en is high; 0 holds the sequencer until the first res_req.

Ports:
- clk  input  1  master clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; low freezes phase, count and pending reset.
- res_req  input  1  synchronous count-reset request (RSYNC style), sampled every clk.
- s1  output  1  phase-1 clock to downstream D1 stages.
- s2  output  1  phase-2 clock to downstream D1 stages.
- count  output  6  current polynomial counter state.
- at_end  output  1  combinational: count == END_VALUE.
- wrap  output  1  one-clk pulse on the tick where count goes END_VALUE -> 000000.

Behaviour:
- Reset (reset_n low, asynchronous):
  - ph=00, count=000000, pend=0, wrap=0, s1=0, s2=0.
  - Run flag = PHASE_EN_RESET.
- Phase sequencer:
  - 2-bit Gray register ph advances 00 -> 01 -> 11 -> 10 -> 00 on each clk where en=1 and the run flag is set.
  - s1 = (ph==01) and s2 = (ph==10), decoded from registered ph.
  - Each phase output is high 1 clk in 4; s1 and s2 never overlap; at least 1 clk separates them.
- Tick:
  - The clk edge where ph leaves 01 (falling edge of s1). This matches the D1 latch-on-s1-fall timing.
  - One tick per 4 enabled clks.
  - The first tick after reset is the 2nd enabled clk edge.
- Count update at a tick, by priority:
  1. pend=1 or res_req=1: count <= 000000, pend <= 0, wrap <= 0.
  2. count==END_VALUE: count <= 000000, wrap <= 1.
  3. Otherwise: count <= {count[4:0], ~(count[5]^count[4])}.
- Non-tick clks: count holds; wrap <= 0. wrap is therefore high for exactly 1 clk.
- Pending reset:
  - res_req=1 on a non-tick clk sets pend; the count clears at the next tick.
  - res_req on the tick edge itself applies to that tick.
  - res_req is ignored when en=0.
- Free-running sequence from 000000: 000001, 000011, 000111, 001111, 011111, 111110, ...
  - Reaches 010100 at tick 59, wraps at tick 60. Period is 60 ticks = 240 enabled clks.
- Run flag with PHASE_EN_RESET=0: set by the first res_req while en=1. That res_req also sets pend.
- en=0: ph, count and pend hold; s1/s2 hold their decoded levels; wrap <= 0.
- Reset mid-operation: everything returns to reset values immediately. No tick or wrap pulse results from reset deassertion.
- Count values outside the sequence, including all-ones behaviour: no special handling; the feedback equation applies.

Test Plan:
- Reset release, en=1, 8 clks -> s1 high on clks 1 and 5, s2 on clks 3 and 7; count = 000001 after clk 2 and 000011 after clk 6.
- Free run 240 clks from reset -> count hits 010100 at tick 59; wrap high exactly 1 clk at tick 60; count=000000 after, then 000001.
- res_req pulsed on a non-tick clk with count=011111 -> count holds until the next tick, then 000000; wrap stays 0.
- res_req asserted on the same edge that count==END_VALUE ticks -> count=000000, wrap=0 (reset has priority).
- en low for 10 clks while ph=01 -> s1 stays high, count frozen; after en returns, the tick occurs on the next enabled edge.
- reset_n asserted mid-sequence (count=110101, ph=11) -> all outputs 0 asynchronously; with PHASE_EN_RESET=0, no s1 appears until res_req is pulsed.
